intc_apb_bridge: RTL and testbench

Parametrised APB slave for the interrupt controller register file, replacing the zero-wait, always-OKAY slave. Converts APB access phases into a registered request/acknowledge transaction toward the register block, with wait states, byte strobes, address-window and alignment checking, and a response timeout. Sits between the SoC APB fabric and the INTC register bank.

---
 rtl/intc_apb_pkg.sv | 22 ++
 rtl/intc_apb_decode.sv | 47 ++++
 rtl/intc_apb_bridge.sv | 172 +++++++++++++++++
 tb/tb_intc_apb_bridge.sv | 220 ++++++++++++++++++++++
 4 files changed

// File: rtl/intc_apb_pkg.sv
// Shared types and helpers for the INTC APB bridge: FSM state encoding,
// response codes and the timeout counter width.
package intc_apb_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      REQ  = 2'd1,
      WAIT = 2'd2,
      RESP = 2'd3
   } apb_state_e;

   localparam logic RESP_OKAY   = 1'b0;
   localparam logic RESP_SLVERR = 1'b1;

   // Width to hold 0..timeout; never narrower than one bit so TIMEOUT=0 still elaborates.
   function automatic int unsigned cnt_width(input int unsigned timeout);
      int unsigned w;
      w = $clog2(timeout + 1);
      return (w == 0) ? 1 : w;
   endfunction

endpackage

// File: rtl/intc_apb_decode.sv
// Combinational access decode: window, alignment, strobe and (with
// INTC_APB_PROT_CHECK_EN) privilege checks; flags error or no-op writes.
module intc_apb_decode
   import intc_apb_pkg::*;
#(
   parameter int unsigned   AW            = 32,
   parameter int unsigned   DW            = 32,
   parameter logic [AW-1:0] BASE_ADDR     = '0,
   parameter int unsigned   WIN_BYTES     = 256,
   parameter bit            ALLOW_PARTIAL = 1'b1
) (
   input  logic [AW-1:0]   paddr_i,
   input  logic            pwrite_i,
   input  logic [DW/8-1:0] pstrb_i,
   input  logic [2:0]      pprot_i,
   output logic            err_o,
   output logic            nop_o,
   output logic [AW-1:0]   offset_o
);

   localparam int unsigned SW  = DW / 8;
   localparam int unsigned AL  = $clog2(SW);
   localparam logic [AW:0] WIN = (AW + 1)'(WIN_BYTES);

   logic in_win;
   logic misalign;
   logic strb_bad;
   logic prot_bad;

`ifdef INTC_APB_PROT_CHECK_EN
   assign prot_bad = ~pprot_i[0];
`else
   logic unused_prot;
   assign unused_prot = ^pprot_i;
   assign prot_bad    = 1'b0;
`endif

   // Offset compare is one bit wider so a window ending at the top of the map is legal.
   assign offset_o = paddr_i - BASE_ADDR;
   assign in_win   = (paddr_i >= BASE_ADDR) && ({1'b0, offset_o} < WIN);
   assign misalign = |paddr_i[AL-1:0];
   assign strb_bad = !ALLOW_PARTIAL && pwrite_i && (pstrb_i != {SW{1'b1}});

   assign err_o = !in_win || misalign || strb_bad || prot_bad;
   assign nop_o = !err_o && ALLOW_PARTIAL && pwrite_i && (pstrb_i == '0);

endmodule

// File: rtl/intc_apb_bridge.sv
// APB slave front-end for the INTC register bank: registered req/ack toward
// the bank with wait states and timeout. Optional macro: INTC_APB_PROT_CHECK_EN.
module intc_apb_bridge
   import intc_apb_pkg::*;
#(
   parameter int unsigned   AW            = 32,
   parameter int unsigned   DW            = 32,
   parameter logic [AW-1:0] BASE_ADDR     = 32'h0000_0000,
   parameter int unsigned   WIN_BYTES     = 256,
   parameter bit            ALLOW_PARTIAL = 1'b1,
   parameter int unsigned   TIMEOUT       = 16
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            psel_i,
   input  logic            penable_i,
   input  logic            pwrite_i,
   input  logic [AW-1:0]   paddr_i,
   input  logic [DW-1:0]   pwdata_i,
   input  logic [DW/8-1:0] pstrb_i,
   input  logic [2:0]      pprot_i,
   output logic [DW-1:0]   prdata_o,
   output logic            pready_o,
   output logic            pslverr_o,
   output logic            bs_sel_o,
   output logic            bs_wr_o,
   output logic [AW-1:0]   bs_addr_o,
   output logic [DW-1:0]   bs_wdata_o,
   output logic [DW/8-1:0] bs_strb_o,
   input  logic            bs_ack_i,
   input  logic [DW-1:0]   bs_rdata_i
);

   localparam int unsigned SW  = DW / 8;
   localparam int unsigned CW  = cnt_width(TIMEOUT);
   localparam logic [CW:0] TMO = (CW + 1)'(TIMEOUT);

   apb_state_e    state_q, state_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic [CW:0]   cnt_inc;
   logic          wr_q, wr_d;
   logic [AW-1:0] addr_q, addr_d;
   logic [DW-1:0] wdata_q, wdata_d;
   logic [SW-1:0] strb_q, strb_d;
   logic          sel_q, sel_d;
   logic          pready_q, pready_d;
   logic          pslverr_q, pslverr_d;
   logic [DW-1:0] prdata_q, prdata_d;

   logic          dec_err;
   logic          dec_nop;
   logic [AW-1:0] dec_offset;

   intc_apb_decode #(
      .AW            (AW),
      .DW            (DW),
      .BASE_ADDR     (BASE_ADDR),
      .WIN_BYTES     (WIN_BYTES),
      .ALLOW_PARTIAL (ALLOW_PARTIAL)
   ) u_decode (
      .paddr_i  (paddr_i),
      .pwrite_i (pwrite_i),
      .pstrb_i  (pstrb_i),
      .pprot_i  (pprot_i),
      .err_o    (dec_err),
      .nop_o    (dec_nop),
      .offset_o (dec_offset)
   );

   assign cnt_inc = {1'b0, cnt_q} + (CW + 1)'(1);

   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      wr_d      = wr_q;
      addr_d    = addr_q;
      wdata_d   = wdata_q;
      strb_d    = strb_q;
      sel_d     = 1'b0;
      pready_d  = 1'b0;
      pslverr_d = RESP_OKAY;
      prdata_d  = '0;

      unique case (state_q)
         IDLE: begin
            if (psel_i && penable_i) begin
               if (dec_err) begin
                  state_d   = RESP;
                  pready_d  = 1'b1;
                  pslverr_d = RESP_SLVERR;
               end else if (dec_nop) begin
                  state_d  = RESP;
                  pready_d = 1'b1;
               end else begin
                  state_d = REQ;
                  sel_d   = 1'b1;
                  wr_d    = pwrite_i;
                  addr_d  = dec_offset;
                  wdata_d = pwdata_i;
                  strb_d  = pwrite_i ? pstrb_i : {SW{1'b1}};
               end
            end
         end
         REQ: begin
            cnt_d = CW'(1);
            if (bs_ack_i) begin
               state_d  = RESP;
               pready_d = 1'b1;
               prdata_d = wr_q ? '0 : bs_rdata_i;
            end else begin
               state_d = WAIT;
            end
         end
         WAIT: begin
            cnt_d = cnt_inc[CW] ? cnt_q : cnt_inc[CW-1:0];
            // Ack is tested first so a coincident ack beats timeout expiry.
            if (bs_ack_i) begin
               state_d  = RESP;
               pready_d = 1'b1;
               prdata_d = wr_q ? '0 : bs_rdata_i;
            end else if ((TIMEOUT != 0) && (cnt_inc >= TMO)) begin
               state_d   = RESP;
               pready_d  = 1'b1;
               pslverr_d = RESP_SLVERR;
            end
         end
         RESP: begin
            state_d = IDLE;
            cnt_d   = '0;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= IDLE;
         cnt_q     <= '0;
         wr_q      <= 1'b0;
         addr_q    <= '0;
         wdata_q   <= '0;
         strb_q    <= '0;
         sel_q     <= 1'b0;
         pready_q  <= 1'b0;
         pslverr_q <= 1'b0;
         prdata_q  <= '0;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         wr_q      <= wr_d;
         addr_q    <= addr_d;
         wdata_q   <= wdata_d;
         strb_q    <= strb_d;
         sel_q     <= sel_d;
         pready_q  <= pready_d;
         pslverr_q <= pslverr_d;
         prdata_q  <= prdata_d;
      end
   end

   assign prdata_o   = prdata_q;
   assign pready_o   = pready_q;
   assign pslverr_o  = pslverr_q;
   assign bs_sel_o   = sel_q;
   assign bs_wr_o    = wr_q;
   assign bs_addr_o  = addr_q;
   assign bs_wdata_o = wdata_q;
   assign bs_strb_o  = strb_q;

endmodule

// File: tb/tb_intc_apb_bridge.sv
// Scoreboard bench for intc_apb_bridge: two instances (default parameters,
// and strict strobes / short timeout / nonzero base) with directed vectors.
module tb_intc_apb_bridge;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        psel_a = 1'b0, psel_b = 1'b0;
   logic        penable = 1'b0;
   logic        pwrite = 1'b0;
   logic [31:0] paddr = '0;
   logic [31:0] pwdata = '0;
   logic [3:0]  pstrb = '0;
   logic [2:0]  pprot = 3'b001;

   logic [31:0] prdata_a, prdata_b, bs_addr_a, bs_addr_b, bs_wdata_a, bs_wdata_b;
   logic        pready_a, pready_b, pslverr_a, pslverr_b;
   logic        bs_sel_a, bs_sel_b, bs_wr_a, bs_wr_b;
   logic [3:0]  bs_strb_a, bs_strb_b;
   logic        bs_ack_a, bs_ack_b;
   logic [31:0] bs_rdata_a = 32'hDEADBEEF;
   logic [31:0] bs_rdata_b = 32'h0BADF00D;

   int          mode_a = 0, mode_b = 0;  // 0 no ack, 1 ack tied high, 2 delayed responder
   logic        pulse_a = 1'b0, pulse_b = 1'b0;
   assign bs_ack_a = (mode_a == 1) | pulse_a;
   assign bs_ack_b = (mode_b == 1) | pulse_b;

   int compared = 0, mismatched = 0;
   int cyc = 0;
   int sel_cnt_a = 0, sel_cnt_b = 0, exp_sel_a = 0, exp_sel_b = 0;

   typedef struct {
      logic        err;
      logic [31:0] rd;
      int          lat;
      int          issue;
   } exp_t;
   exp_t q_a[$], q_b[$];
   exp_t e_a, e_b;

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   intc_apb_bridge u_a (
      .clk(clk), .rst_n(rst_n), .psel_i(psel_a), .penable_i(penable), .pwrite_i(pwrite),
      .paddr_i(paddr), .pwdata_i(pwdata), .pstrb_i(pstrb), .pprot_i(pprot),
      .prdata_o(prdata_a), .pready_o(pready_a), .pslverr_o(pslverr_a),
      .bs_sel_o(bs_sel_a), .bs_wr_o(bs_wr_a), .bs_addr_o(bs_addr_a),
      .bs_wdata_o(bs_wdata_a), .bs_strb_o(bs_strb_a), .bs_ack_i(bs_ack_a), .bs_rdata_i(bs_rdata_a)
   );

   intc_apb_bridge #(
      .BASE_ADDR(32'h0000_1000), .ALLOW_PARTIAL(1'b0), .TIMEOUT(4)
   ) u_b (
      .clk(clk), .rst_n(rst_n), .psel_i(psel_b), .penable_i(penable), .pwrite_i(pwrite),
      .paddr_i(paddr), .pwdata_i(pwdata), .pstrb_i(pstrb), .pprot_i(pprot),
      .prdata_o(prdata_b), .pready_o(pready_b), .pslverr_o(pslverr_b),
      .bs_sel_o(bs_sel_b), .bs_wr_o(bs_wr_b), .bs_addr_o(bs_addr_b),
      .bs_wdata_o(bs_wdata_b), .bs_strb_o(bs_strb_b), .bs_ack_i(bs_ack_b), .bs_rdata_i(bs_rdata_b)
   );

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      compared++;
      if (act !== exp) begin
         mismatched++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // Monitors: pop the expected response whenever a DUT raises pready.
   always @(negedge clk) begin
      if (bs_sel_a) sel_cnt_a++;
      if (pready_a) begin
         if (q_a.size() == 0) check("a_unexpected_pready", 1, 0);
         else begin
            e_a = q_a.pop_front();
            check("a_pslverr", 64'(pslverr_a), 64'(e_a.err));
            check("a_prdata", 64'(prdata_a), 64'(e_a.rd));
            check("a_latency", 64'(cyc - e_a.issue), 64'(e_a.lat));
         end
      end
   end

   always @(negedge clk) begin
      if (bs_sel_b) sel_cnt_b++;
      if (pready_b) begin
         if (q_b.size() == 0) check("b_unexpected_pready", 1, 0);
         else begin
            e_b = q_b.pop_front();
            check("b_pslverr", 64'(pslverr_b), 64'(e_b.err));
            check("b_prdata", 64'(prdata_b), 64'(e_b.rd));
            check("b_latency", 64'(cyc - e_b.issue), 64'(e_b.lat));
         end
      end
   end

   // Delayed responder for instance a: strobes must stay stable while it waits.
   initial begin
      forever begin
         @(negedge clk);
         if (mode_a == 2 && bs_sel_a) begin
            check("a_req_wr", 64'(bs_wr_a), 64'(1));
            check("a_req_addr", 64'(bs_addr_a), 64'h14);
            check("a_req_wdata", 64'(bs_wdata_a), 64'h12345678);
            for (int i = 0; i < 5; i++) begin
               @(negedge clk);
               check("a_wait_sel_low", 64'(bs_sel_a), 64'(0));
               check("a_wait_strb_hold", 64'(bs_strb_a), 64'h3);
            end
            pulse_a = 1'b1;
            @(posedge clk);
            #1 pulse_a = 1'b0;
         end
      end
   end

   task automatic apb(input bit b, input bit wr, input logic [31:0] addr, input logic [31:0] data,
                      input logic [3:0] strb, input logic [2:0] prot,
                      input bit exp_err, input logic [31:0] exp_rd, input int lat, input bit exp_sel);
      exp_t e;
      bit   seen;
      @(posedge clk);
      #1;
      if (b) psel_b = 1'b1; else psel_a = 1'b1;
      penable = 1'b0; pwrite = wr; paddr = addr; pwdata = data; pstrb = strb; pprot = prot;
      @(posedge clk);
      #1 penable = 1'b1;
      e.err = exp_err; e.rd = exp_rd; e.lat = lat; e.issue = cyc;
      if (b) begin q_b.push_back(e); if (exp_sel) exp_sel_b++; end
      else   begin q_a.push_back(e); if (exp_sel) exp_sel_a++; end
      seen = 1'b0;
      for (int i = 0; i < 40 && !seen; i++) begin
         @(negedge clk);
         seen = b ? pready_b : pready_a;
      end
      if (!seen) check("pready_timeout", 0, 1);
      @(posedge clk);
      #1 psel_a = 1'b0; psel_b = 1'b0; penable = 1'b0;
   endtask

   initial begin
      repeat (3) @(posedge clk);
      #1;
      check("reset_outputs_a", {prdata_a, pready_a, pslverr_a, bs_sel_a, bs_wr_a, bs_strb_a}, '0);
      check("reset_outputs_b", {bs_addr_b, pready_b, pslverr_b, bs_sel_b}, '0);
      rst_n = 1'b1;

      // Instance a: defaults (base 0, partial strobes allowed, timeout 16)
      mode_a = 1;
      apb(0, 0, 32'h10, 0, 4'hF, 3'b001, 1'b0, 32'hDEADBEEF, 2, 1);
      check("a_read_addr", 64'(bs_addr_a), 64'h10);
      check("a_read_strb", 64'(bs_strb_a), 64'hF);
      check("a_read_wr", 64'(bs_wr_a), 64'(0));
      mode_a = 2;
      apb(0, 1, 32'h14, 32'h12345678, 4'b0011, 3'b001, 1'b0, 32'h0, 7, 1);
      mode_a = 1;
      apb(0, 0, 32'h100, 0, 4'hF, 3'b001, 1'b1, 32'h0, 1, 0);   // first byte past window
      apb(0, 0, 32'h11, 0, 4'hF, 3'b001, 1'b1, 32'h0, 1, 0);    // misaligned
      apb(0, 1, 32'h20, 32'hFFFF, 4'b0000, 3'b001, 1'b0, 32'h0, 1, 0);  // no-op write
      apb(0, 0, 32'hFC, 0, 4'hF, 3'b001, 1'b0, 32'hDEADBEEF, 2, 1);     // last word in window

      // Reset while waiting for the bank
      mode_a = 0;
      @(posedge clk);
      #1 psel_a = 1'b1; penable = 1'b0; pwrite = 1'b0; paddr = 32'h20; pprot = 3'b001;
      @(posedge clk);
      #1 penable = 1'b1;
      exp_sel_a++;
      repeat (3) @(negedge clk);
      rst_n = 1'b0;
      #1;
      check("a_reset_in_wait", {prdata_a, pready_a, pslverr_a, bs_sel_a, bs_wr_a, bs_addr_a, bs_strb_a}, '0);
      psel_a = 1'b0; penable = 1'b0;
      mode_a = 1;
      @(posedge clk);
      @(posedge clk);
      #1 rst_n = 1'b1;
      apb(0, 0, 32'h30, 0, 4'hF, 3'b001, 1'b0, 32'hDEADBEEF, 2, 1);

`ifdef INTC_APB_PROT_CHECK_EN
      apb(0, 0, 32'h10, 0, 4'hF, 3'b000, 1'b1, 32'h0, 1, 0);
`else
      apb(0, 0, 32'h10, 0, 4'hF, 3'b000, 1'b0, 32'hDEADBEEF, 2, 1);
`endif
      apb(0, 0, 32'h10, 0, 4'hF, 3'b001, 1'b0, 32'hDEADBEEF, 2, 1);

      // Instance b: base 0x1000, full strobes required, timeout 4
      mode_b = 1;
      apb(1, 1, 32'h1014, 32'h12345678, 4'b0011, 3'b001, 1'b1, 32'h0, 1, 0);
      apb(1, 0, 32'h1100, 0, 4'hF, 3'b001, 1'b1, 32'h0, 1, 0);
      apb(1, 0, 32'h0FFC, 0, 4'hF, 3'b001, 1'b1, 32'h0, 1, 0);   // just below base
      mode_b = 0;
      apb(1, 0, 32'h1004, 0, 4'hF, 3'b001, 1'b1, 32'h0, 5, 1);   // timeout
      @(posedge clk);
      #1 pulse_b = 1'b1;
      repeat (2) @(posedge clk);
      #1 pulse_b = 1'b0;
      mode_b = 1;
      apb(1, 0, 32'h1008, 0, 4'hF, 3'b001, 1'b0, 32'h0BADF00D, 2, 1);
      check("b_read_offset", 64'(bs_addr_b), 64'h8);
      apb(1, 1, 32'h100C, 32'hA5A5A5A5, 4'hF, 3'b001, 1'b0, 32'h0, 2, 1);
      check("b_write_wdata", 64'(bs_wdata_b), 64'hA5A5A5A5);

      repeat (3) @(posedge clk);
      #1;
      check("a_sel_pulses", 64'(sel_cnt_a), 64'(exp_sel_a));
      check("b_sel_pulses", 64'(sel_cnt_b), 64'(exp_sel_b));
      check("a_queue_drained", 64'(q_a.size()), 64'(0));
      check("b_queue_drained", 64'(q_b.size()), 64'(0));
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL global_timeout: simulation did not finish, compared %0d", compared);
      $fatal(1);
   end

endmodule
